adbg_spr_burst_biu: RTL

Parametrised CPU-domain SPR bus engine for the advanced debug unit. It accepts already-synchronised burst commands from the debug module, runs them as 1..2^LEN_W SPR accesses, and returns read data through an internal FIFO. Accesses can target one core, or several cores at once for broadcast writes. Every access is guarded by a timeout, and failures are reported per core. It sits between the TCK→CPU command CDC and the per-core SPR ports.

---
 rtl/adbg_biu_pkg.sv | 22 ++
 rtl/adbg_sync_fifo.sv | 66 ++++++
 rtl/adbg_spr_burst_biu.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/adbg_biu_pkg.sv
// Shared types for the advanced-debug SPR burst bus engine: FSM states and the
// sizing rule for the per-access timeout counter.
package adbg_biu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_ACCESS,
    ST_RSPACE,
    ST_FLUSH,
    ST_DONE
  } biu_state_e;

  localparam int unsigned TIMEOUT_DEF = 255;
  localparam int unsigned CNT_W_DEF   = $clog2(TIMEOUT_DEF + 1);

  // A disabled timeout (0) still needs a legal one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/adbg_sync_fifo.sv
// Single-clock read-data FIFO; the head is read straight from storage flops so
// data pushed at an edge is visible on data_o the following cycle.
module adbg_sync_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              cpu_clk_i,
  input  logic              trstn_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              empty_o,
  output logic              full_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic              push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];

  // NOTE: every signal written in always_comb gets a default first, so no path
  // can leave it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of the others, whatever the order of the statements.
  always_ff @(posedge cpu_clk_i or negedge trstn_i) begin
    if (!trstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers and count
  // already mark it empty, and a reset on a memory blocks RAM inference.
  always_ff @(posedge cpu_clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/adbg_spr_burst_biu.sv
// CPU-domain SPR burst engine: runs accepted burst commands as single or
// broadcast SPR accesses with per-access timeout and a read-data FIFO.
module adbg_spr_burst_biu
  import adbg_biu_pkg::*;
#(
  parameter int NB_CORES   = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic                         cpu_clk_i,
  input  logic                         trstn_i,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [NB_CORES-1:0]          cmd_mask_i,
  input  logic [ADDR_W-1:0]            cmd_addr_i,
  input  logic [LEN_W-1:0]             cmd_len_i,
  input  logic                         cmd_rd_wrn_i,
  input  logic                         cmd_incr_i,
  input  logic                         wdata_valid_i,
  output logic                         wdata_ready_o,
  input  logic [DATA_W-1:0]            wdata_i,
  output logic                         rdata_valid_o,
  input  logic                         rdata_ready_i,
  output logic [DATA_W-1:0]            rdata_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [NB_CORES-1:0]          err_core_o,
  input  logic                         err_clr_i,
  output logic [NB_CORES*ADDR_W-1:0]   cpu_addr_o,
  output logic [NB_CORES*DATA_W-1:0]   cpu_data_o,
  output logic [NB_CORES-1:0]          cpu_we_o,
  output logic [NB_CORES-1:0]          cpu_stb_o,
  input  logic [NB_CORES*DATA_W-1:0]   cpu_data_i,
  input  logic [NB_CORES-1:0]          cpu_ack_i
);

  localparam int CNT_W = cnt_width(TIMEOUT);

  biu_state_e          state_q, state_d;
  logic [NB_CORES-1:0] mask_q, mask_d;
  logic [NB_CORES-1:0] pending_q, pending_d;
  logic [NB_CORES-1:0] err_core_q, err_core_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    rem_q, rem_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rd_wrn_q, rd_wrn_d;
  logic                incr_q, incr_d;
  logic                err_q, err_d;

  logic [NB_CORES-1:0] pend_left, err_core_set;
  logic [DATA_W-1:0]   rd_sel;
  logic                err_set, cmd_illegal, timeout_hit;
  logic                fifo_push, fifo_full, fifo_empty;

  assign pend_left   = pending_q & ~cpu_ack_i;
  // Broadcast is write-only: a read needs exactly one target to source data.
  assign cmd_illegal = (cmd_mask_i == '0) ||
                       (cmd_rd_wrn_i && ((cmd_mask_i & (cmd_mask_i - NB_CORES'(1))) != '0));
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1)) && (pend_left != '0);

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      if (mask_q[i]) rd_sel |= cpu_data_i[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge cpu_clk_i or negedge trstn_i) begin
    if (!trstn_i) begin
      state_q    <= ST_IDLE;
      mask_q     <= '0;
      pending_q  <= '0;
      err_core_q <= '0;
      addr_q     <= '0;
      rem_q      <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      rd_wrn_q   <= 1'b0;
      incr_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      pending_q  <= pending_d;
      err_core_q <= err_core_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      rd_wrn_q   <= rd_wrn_d;
      incr_q     <= incr_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    pending_d    = pending_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    rd_wrn_d     = rd_wrn_q;
    incr_d       = incr_q;
    err_set      = 1'b0;
    err_core_set = '0;
    fifo_push    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          mask_d   = cmd_mask_i;
          addr_d   = cmd_addr_i;
          rem_d    = cmd_len_i;
          rd_wrn_d = cmd_rd_wrn_i;
          incr_d   = cmd_incr_i;
          if (cmd_illegal) begin
            err_set = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = cmd_rd_wrn_i ? ST_RSPACE : ST_WDATA;
          end
        end
      end
      ST_WDATA: begin
        if (wdata_valid_i) begin
          wdata_d   = wdata_i;
          pending_d = mask_q;
          cnt_d     = '0;
          state_d   = ST_ACCESS;
        end
      end
      ST_RSPACE: begin
        if (!fifo_full) begin
          pending_d = mask_q;
          cnt_d     = '0;
          state_d   = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        pending_d = pend_left;
        cnt_d     = cnt_q + 1'b1;
        fifo_push = rd_wrn_q && ((pending_q & cpu_ack_i) != '0);
        if (pend_left == '0) begin
          if (rem_q == '0) begin
            state_d = ST_DONE;
          end else begin
            rem_d   = rem_q - 1'b1;
            addr_d  = addr_q + ADDR_W'(incr_q);
            state_d = rd_wrn_q ? ST_RSPACE : ST_WDATA;
          end
        end else if (timeout_hit) begin
          err_set      = 1'b1;
          err_core_set = pend_left;
          pending_d    = '0;
          // Remaining write beats are still owed by the producer; drain them.
          state_d      = (!rd_wrn_q && rem_q != '0) ? ST_FLUSH : ST_DONE;
        end
      end
      ST_FLUSH: begin
        if (wdata_valid_i) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Clear first, then set, so a same-cycle error survives err_clr_i.
    err_d      = (err_clr_i ? 1'b0 : err_q) | err_set;
    err_core_d = (err_clr_i ? '0 : err_core_q) | err_core_set;
  end

  always_comb begin
    cmd_ready_o   = (state_q == ST_IDLE);
    wdata_ready_o = (state_q == ST_WDATA) || (state_q == ST_FLUSH);
    busy_o        = (state_q != ST_IDLE);
    done_o        = (state_q == ST_DONE);
    err_o         = err_q;
    err_core_o    = err_core_q;
    cpu_stb_o     = (state_q == ST_ACCESS) ? pending_q : '0;
    cpu_we_o      = rd_wrn_q ? '0 : cpu_stb_o;
    cpu_addr_o    = '0;
    cpu_data_o    = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      if (cpu_stb_o[i]) cpu_addr_o[i*ADDR_W +: ADDR_W] = addr_q;
      if (cpu_we_o[i])  cpu_data_o[i*DATA_W +: DATA_W] = wdata_q;
    end
  end

  adbg_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_rd_fifo (
    .cpu_clk_i (cpu_clk_i),
    .trstn_i   (trstn_i),
    .push_i    (fifo_push),
    .data_i    (rd_sel),
    .pop_i     (rdata_ready_i),
    .data_o    (rdata_o),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full)
  );

  assign rdata_valid_o = ~fifo_empty;

endmodule
